simm_controller: RTL and testbench
==================================

# simm_controller

Fast-page-less DRAM controller for the 72-pin SIMM slot, instantiated in the core directly downstream of the address decoder. It consumes the SIMM device select and byte-lane strobes and generates multiplexed row/column address, RAS, CAS and WE, plus CAS-before-RAS refresh. It supplies a `waitstate` signal the core uses to hold off DSACK (DSACK = 2'b11 while `waitstate & cs`), exactly as for the QUART.

## Interface
- `REFRESH_INTERVAL`, 12'd300: clocks between refresh requests (15.6 µs at 20 MHz, with margin).
- `PRECHARGE_CYCLES`, 2'd2: clocks RAS is held high after any cycle (tRP).
- `REFRESH_RAS_CYCLES`, 2'd3: clocks RAS is held low during refresh (tRAS).
- `clock`  in  1  system clock.
- `reset`  in  1  reset; one clock; reset is asynchronous and active-high.
- `cs`  in  1  device_selected SIMM bit from the decoder.
- `as`  in  1  address strobe, positive logic.
- `write`  in  1  ds & ~rn_w.
- `addr`  in  25  CPU addr[24:0].
- `upper_upper`, `upper_mid`, `lower_mid`, `lower_lower`  in  1 each  byte lanes D31-24, D23-16, D15-8, D7-0.
- `waitstate`  out  1  high while an SIMM access is not yet ready.
- `n_ras0`  out  4  bank 0 RAS, all four bits driven identically.
- `n_ras1`  out  4  bank 1 RAS, all four bits identical.
- `n_cas`  out  4  n_cas[3] = D31-24 … n_cas[0] = D7-0.
- `n_simm_we`  out  1  DRAM write enable.
- `simm_addr`  out  12  multiplexed address.

## Operation
- Address split: column = addr[11:2] zero-extended to 12 bits; row = addr[23:12]; bank = addr[24].
- `waitstate` = cs & ~ready; `ready` registered, set on entry to CAS, cleared on exit.
- States: IDLE, ROW, COL, CAS, RF_CAS, RF_RAS, PRECHARGE.
- IDLE: refresh_pending → RF_CAS (priority over access); else cs & as → ROW; else stay.
- ROW: selected bank RAS low, simm_addr = row, n_simm_we = ~write (early write). → COL.
- COL: simm_addr = column, RAS held. → CAS.
- CAS: read asserts all four CAS; write asserts only selected lanes; ready = 1. Hold while as; on ~as → PRECHARGE.
- RF_CAS: all CAS low, all RAS high, WE high; clears refresh_pending. → RF_RAS.
- RF_RAS: all CAS low, both banks' RAS low for REFRESH_RAS_CYCLES. → PRECHARGE.
- PRECHARGE: RAS, CAS, WE high for PRECHARGE_CYCLES, simm_addr holds. → IDLE.
- Refresh counter: free-running, 12 bits, counts 0..REFRESH_INTERVAL-1; on wrap sets refresh_pending. Wrap with pending already set: stays set (no queueing).
- as dropping in ROW or COL (aborted cycle): finish through CAS-less path → PRECHARGE; no CAS asserted.

## Timing
- Reset values: n_ras0 = n_ras1 = n_cas = 4'hf, n_simm_we = 1, simm_addr = 12'h000, ready = 0, state IDLE, counter 0, pending 0. Reset mid-cycle forces these immediately (async).
- All DRAM outputs registered; no combinational path from addr to pins.
- Access latency: cs & as sampled at edge N → RAS low after N+1, column after N+2, CAS low and waitstate low after N+3.
- Refresh arriving with cs in the same IDLE cycle: refresh first; waitstate stays high; access starts after PRECHARGE, i.e. 1 + REFRESH_RAS_CYCLES + PRECHARGE_CYCLES extra clocks.
- Back-to-back accesses always separated by PRECHARGE_CYCLES.

## Configuration
- `SIMM_BANK1_EN` defined: addr[24] selects bank; n_ras1 driven for bank-1 accesses and refresh.
- Undefined: addr[24] ignored (bank 0 aliased over 32 MB), n_ras1 tied to 4'hf, refresh drives bank 0 only.

## Test plan
- Reset asserted mid-CAS → all RAS/CAS/WE high same cycle, waitstate = cs, state IDLE after release.
- Long read at 0x00123454 → simm_addr 12'h123 with n_ras0 = 4'h0, then 12'h115, n_cas = 4'h0, waitstate low 3 clocks after cs, n_ras1 = 4'hf.
- Byte write upper_upper to 0x01000000 (SIMM_BANK1_EN) → n_ras1 = 4'h0, n_simm_we low from ROW, n_cas = 4'b0111; without macro → n_ras0 used.
- Idle 300 clocks → RF_CAS: n_cas = 4'h0 with RAS high one clock, then RAS low 3 clocks, then 2 clocks precharge.
- cs asserted on the exact cycle refresh_pending sets → refresh completes first, access CAS asserted 9 clocks after cs.
- Two consecutive reads → RAS high for exactly 2 clocks between them.

Source files
------------

// File: rtl/simm_controller.sv
// DRAM controller for the 72-pin SIMM slot: RAS/CAS/WE sequencing, row/column
// multiplexing and CAS-before-RAS refresh. Define SIMM_BANK1_EN to decode addr[24] as bank.
module simm_controller #(
  parameter logic [11:0] REFRESH_INTERVAL   = 12'd300,
  parameter logic [1:0]  PRECHARGE_CYCLES   = 2'd2,
  parameter logic [1:0]  REFRESH_RAS_CYCLES = 2'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        as,
  input  logic        write,
  input  logic [24:0] addr,
  input  logic        upper_upper,
  input  logic        upper_mid,
  input  logic        lower_mid,
  input  logic        lower_lower,
  output logic        waitstate,
  output logic [3:0]  n_ras0,
  output logic [3:0]  n_ras1,
  output logic [3:0]  n_cas,
  output logic        n_simm_we,
  output logic [11:0] simm_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_CAS,
    S_RF_CAS,
    S_RF_RAS,
    S_PRECHARGE
  } state_e;

  // The IDLE cycle after PRECHARGE also drives RAS high, so PRECHARGE itself
  // occupies one clock fewer than the total precharge time.
  localparam logic [1:0] PRE_LAST = (PRECHARGE_CYCLES > 2'd1) ? PRECHARGE_CYCLES - 2'd2 : 2'd0;
  localparam logic [1:0] RAS_LAST = (REFRESH_RAS_CYCLES > 2'd0) ? REFRESH_RAS_CYCLES - 2'd1 : 2'd0;

`ifdef SIMM_BANK1_EN
  localparam logic BANK1_EN = 1'b1;
  logic       bank;
  logic [1:0] unused_addr_bits;
  assign bank             = addr[24];
  assign unused_addr_bits = addr[1:0];
`else
  localparam logic BANK1_EN = 1'b0;
  logic       bank;
  logic [2:0] unused_addr_bits;
  assign bank             = 1'b0;
  assign unused_addr_bits = {addr[24], addr[1:0]};
`endif

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] rcnt_q, rcnt_d;
  logic        pending_q, pending_d;
  logic        ready_q, ready_d;
  logic [3:0]  ras0_q, ras0_d;
  logic [3:0]  ras1_q, ras1_d;
  logic [3:0]  cas_q, cas_d;
  logic        we_q, we_d;
  logic [11:0] saddr_q, saddr_d;
  logic        wrap;
  logic [3:0]  lanes;

  assign lanes = {upper_upper, upper_mid, lower_mid, lower_lower};
  assign wrap  = (rcnt_q == REFRESH_INTERVAL - 12'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    rcnt_d    = wrap ? '0 : rcnt_q + 12'd1;
    pending_d = pending_q | wrap;
    ready_d   = 1'b0;
    ras0_d    = '1;
    ras1_d    = '1;
    cas_d     = '1;
    we_d      = 1'b1;
    saddr_d   = saddr_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d   = S_RF_CAS;
          pending_d = wrap;
        end else if (cs && as) begin
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        if (bank) ras1_d = '0;
        else      ras0_d = '0;
        saddr_d = addr[23:12];
        we_d    = ~write;
        state_d = as ? S_COL : S_PRECHARGE;
      end
      S_COL: begin
        ras0_d  = ras0_q;
        ras1_d  = ras1_q;
        we_d    = we_q;
        saddr_d = {2'b00, addr[11:2]};
        state_d = as ? S_CAS : S_PRECHARGE;
      end
      S_CAS: begin
        ras0_d  = ras0_q;
        ras1_d  = ras1_q;
        we_d    = we_q;
        cas_d   = we_q ? 4'h0 : ~lanes;
        ready_d = 1'b1;
        if (!as) state_d = S_PRECHARGE;
      end
      S_RF_CAS: begin
        cas_d   = '0;
        state_d = S_RF_RAS;
      end
      S_RF_RAS: begin
        cas_d  = '0;
        ras0_d = '0;
        ras1_d = BANK1_EN ? 4'h0 : 4'hf;
        if (cnt_q >= RAS_LAST) state_d = S_PRECHARGE;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      S_PRECHARGE: begin
        if (cnt_q >= PRE_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      ras0_q    <= '1;
      ras1_q    <= '1;
      cas_q     <= '1;
      we_q      <= 1'b1;
      saddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      ras0_q    <= ras0_d;
      ras1_q    <= ras1_d;
      cas_q     <= cas_d;
      we_q      <= we_d;
      saddr_q   <= saddr_d;
    end
  end

  assign waitstate = cs & ~ready_q;
  assign n_ras0    = ras0_q;
  assign n_ras1    = ras1_q;
  assign n_cas     = cas_q;
  assign n_simm_we = we_q;
  assign simm_addr = saddr_q;

endmodule

// File: tb/tb_simm_controller.sv
// Randomized bench for simm_controller: a timeline model predicts every pin each
// clock from access/refresh start and end times, refresh interval and precharge time.
module tb_simm_controller;

  localparam int unsigned RI = 300;
  localparam int unsigned PC = 2;
  localparam int unsigned RF = 3;
  localparam int unsigned NP = 130;
  localparam int unsigned INF = 32'hffff_ffff;
`ifdef SIMM_BANK1_EN
  localparam bit BANK1 = 1'b1;
`else
  localparam bit BANK1 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_i, as_i, write_i;
  logic [24:0] addr_i;
  logic [3:0]  lanes;
  logic        waitstate;
  logic [3:0]  n_ras0, n_ras1, n_cas;
  logic        n_simm_we;
  logic [11:0] simm_addr;

  always #5 clk = ~clk;

  simm_controller #(
    .REFRESH_INTERVAL  (12'd300),
    .PRECHARGE_CYCLES  (2'd2),
    .REFRESH_RAS_CYCLES(2'd3)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .cs         (cs_i),
    .as         (as_i),
    .write      (write_i),
    .addr       (addr_i),
    .upper_upper(lanes[3]),
    .upper_mid  (lanes[2]),
    .lower_mid  (lanes[1]),
    .lower_lower(lanes[0]),
    .waitstate  (waitstate),
    .n_ras0     (n_ras0),
    .n_ras1     (n_ras1),
    .n_cas      (n_cas),
    .n_simm_we  (n_simm_we),
    .simm_addr  (simm_addr)
  );

  typedef struct {
    logic [24:0] addr;
    logic        wr;
    logic [3:0]  ln;
    int unsigned gap;
    int unsigned len;
    bit          align;
    bit          rst_mid;
  } txn_t;

  typedef enum {A_NONE, A_ACC, A_REF} act_e;

  txn_t        plan [NP];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // model state: edges counted from reset release
  int unsigned edge_n, avail, ax, ad, cyc;
  bit          pend, ad_known, a_wr;
  act_e        act;
  logic [3:0]  e_ras0, e_ras1, e_cas;
  logic        e_we, e_rdy;
  logic [11:0] e_addr;

  // stimulus state
  int unsigned pi, gap_cnt, t_assert, t_len, tail;
  bit          busy, rst_armed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n   = 0;
    avail    = 1;
    pend     = 1'b0;
    act      = A_NONE;
    ax       = 0;
    ad       = 0;
    ad_known = 1'b0;
    a_wr     = 1'b0;
    e_addr   = '0;
  endtask

  task automatic model_edge();
    int unsigned y, lim;
    bit bank;
    edge_n++;
    y = edge_n;
    if (act == A_ACC && !ad_known && y >= ax + 1 && !as_i) begin
      ad       = y;
      ad_known = 1'b1;
      avail    = y + PC;
    end else if (y >= avail) begin
      if (pend) begin
        act   = A_REF;
        ax    = y;
        avail = y + 1 + RF + PC;
        pend  = 1'b0;
      end else if (cs_i && as_i) begin
        act      = A_ACC;
        ax       = y;
        ad_known = 1'b0;
        avail    = INF;
      end
    end
    if (y % RI == 0) pend = 1'b1;

    e_ras0 = '1; e_ras1 = '1; e_cas = '1; e_we = 1'b1; e_rdy = 1'b0;
    bank = BANK1 && addr_i[24];
    if (act == A_ACC) begin
      lim = ad_known ? ad : INF;
      if (y == ax + 1) begin
        a_wr   = write_i;
        e_addr = addr_i[23:12];
      end else if (y == ax + 2 && y <= lim) begin
        e_addr = {2'b00, addr_i[11:2]};
      end
      if (y >= ax + 1 && y <= lim) begin
        if (bank) e_ras1 = '0;
        else      e_ras0 = '0;
        e_we = ~a_wr;
        if (y >= ax + 3) begin
          e_cas = a_wr ? ~lanes : 4'h0;
          e_rdy = 1'b1;
        end
      end
    end else if (act == A_REF) begin
      if (y >= ax + 1 && y <= ax + 1 + RF) begin
        e_cas = '0;
        if (y >= ax + 2) begin
          e_ras0 = '0;
          if (BANK1) e_ras1 = '0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("n_ras0", 32'(n_ras0), 32'(e_ras0));
    check_val("n_ras1", 32'(n_ras1), 32'(e_ras1));
    check_val("n_cas", 32'(n_cas), 32'(e_cas));
    check_val("n_simm_we", 32'(n_simm_we), 32'(e_we));
    check_val("simm_addr", 32'(simm_addr), 32'(e_addr));
    check_val("waitstate", 32'(waitstate), 32'(cs_i & ~e_rdy));
  endtask

  task automatic check_reset_pins();
    check_val("rst_n_ras0", 32'(n_ras0), 32'h0000_000f);
    check_val("rst_n_ras1", 32'(n_ras1), 32'h0000_000f);
    check_val("rst_n_cas", 32'(n_cas), 32'h0000_000f);
    check_val("rst_n_simm_we", 32'(n_simm_we), 32'h1);
    check_val("rst_simm_addr", 32'(simm_addr), 32'h0);
    check_val("rst_waitstate", 32'(waitstate), 32'(cs_i));
  endtask

  task automatic idle_inputs();
    cs_i    = ($urandom_range(3, 0) == 0);
    as_i    = 1'b0;
    addr_i  = 25'($urandom);
    write_i = 1'($urandom_range(1, 0));
    lanes   = 4'($urandom);
  endtask

  task automatic drive();
    if (!busy) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
        idle_inputs();
      end else if (pi < NP && (!plan[pi].align || (edge_n % RI) == 0)) begin
        addr_i    = plan[pi].addr;
        write_i   = plan[pi].wr;
        lanes     = plan[pi].ln;
        cs_i      = 1'b1;
        as_i      = 1'b1;
        busy      = 1'b1;
        t_assert  = edge_n;
        t_len     = plan[pi].len;
        rst_armed = plan[pi].rst_mid;
      end else begin
        idle_inputs();
      end
    end else if (act == A_ACC && ax > t_assert && edge_n + 1 >= ax + t_len) begin
      cs_i = 1'b0;
      as_i = 1'b0;
      busy = 1'b0;
      pi++;
      if (pi < NP) gap_cnt = plan[pi].gap;
    end
  endtask

  task automatic set_txn(input int unsigned i, input logic [24:0] a, input logic w,
                         input logic [3:0] l, input int unsigned g, input int unsigned n,
                         input bit al, input bit rm);
    plan[i].addr    = a;
    plan[i].wr      = w;
    plan[i].ln      = l;
    plan[i].gap     = g;
    plan[i].len     = n;
    plan[i].align   = al;
    plan[i].rst_mid = rm;
  endtask

  initial begin
    set_txn(0, 25'h0123454, 1'b0, 4'hf, 0, 8, 1'b0, 1'b1);
    set_txn(1, 25'h0123454, 1'b0, 4'hf, 2, 5, 1'b0, 1'b0);
    set_txn(2, 25'h0000ffc, 1'b0, 4'h3, 0, 3, 1'b0, 1'b0);
    set_txn(3, 25'h1000000, 1'b1, 4'b1000, 0, 4, 1'b0, 1'b0);
    set_txn(4, 25'h1abcdef, 1'b0, 4'hf, 1, 1, 1'b0, 1'b0);
    set_txn(5, 25'h0555554, 1'b1, 4'b0101, 0, 2, 1'b0, 1'b0);
    set_txn(6, 25'h0abcdef, 1'b1, 4'b0011, 320, 4, 1'b0, 1'b0);
    set_txn(7, 25'h0123454, 1'b0, 4'hf, 0, 4, 1'b1, 1'b0);
    for (int unsigned i = 8; i < NP; i++) begin
      set_txn(i, 25'($urandom), 1'($urandom_range(1, 0)), 4'($urandom),
              ($urandom_range(7, 0) == 0) ? $urandom_range(400, 20) : $urandom_range(3, 0),
              $urandom_range(8, 1), ($urandom_range(11, 0) == 0), 1'b0);
    end

    rst = 1'b0; cs_i = 1'b0; as_i = 1'b0; write_i = 1'b0; addr_i = '0; lanes = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_pins();
    rst = 1'b0;
    model_reset();
    pi = 0; gap_cnt = plan[0].gap; busy = 1'b0; rst_armed = 1'b0; tail = 0; cyc = 0;

    while (1) begin
      if (pi >= NP) begin
        if (tail >= 12) break;
        tail++;
      end
      if (cyc >= 80000) begin
        check_val("cycle_budget", pi, NP);
        break;
      end
      drive();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
      if (rst_armed && act == A_ACC && edge_n == ax + 4) begin
        rst_armed = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_pins();
        @(negedge clk);
        cs_i = 1'b0;
        as_i = 1'b0;
        @(negedge clk);
        check_reset_pins();
        rst = 1'b0;
        model_reset();
        busy = 1'b0;
        pi++;
        gap_cnt = plan[pi].gap;
        continue;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
